// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit indices and multiplier FSM state type
// shared by alu_seq and its shift-add multiplier alu_mul.
package alu_pkg;

   localparam logic [3:0] OP_ZERO = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_INC  = 4'h3;
   localparam logic [3:0] OP_DEC  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_NOT  = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_SHL  = 4'h9;
   localparam logic [3:0] OP_PASS = 4'hA;
   localparam logic [3:0] OP_MUL  = 4'hB;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 3;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } mul_state_e;

endpackage

// File: rtl/alu_mul.sv
// alu_mul: WIDTH-iteration shift-add multiplier with IDLE/MUL FSM.
// Ports: clk, rst (sync, active high), go, mcand, mplier in;
//        busy (registered), last (final iteration), prod (result
//        presented during the final iteration) out.
module alu_mul
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               go,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               busy,
   output logic               last,
   output logic [2*WIDTH-1:0] prod
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   mul_state_e           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic                 busy_q, busy_d;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   step;

   // acc = {partial, remaining multiplier bits}; each step adds the
   // multiplicand into the upper half when the current LSB is set,
   // then shifts the whole accumulator right by one.
   always_comb begin
      sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
          + (acc_q[0] ? {1'b0, mcand_q} : '0);
      step = {sum, acc_q[WIDTH-1:1]};

      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      busy_d  = busy_q;
      last    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_MUL;
               cnt_d   = '0;
               acc_d   = {{WIDTH{1'b0}}, mplier};
               mcand_d = mcand;
               busy_d  = 1'b1;
            end
         end
         S_MUL: begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               last    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign prod = step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with {N,V,C,Z} flags, start/done handshake
// and optional multi-cycle MUL (opcode B) built when ALU_SEQ_MUL_EN is
// defined; otherwise opcode B is treated as undefined.
// Ports: clk, rst (sync, active high), start, alus[3:0], x, bus in;
//        dout, prod_hi, flags[3:0], ill, busy, done out (all registered).
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alus,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] bus,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] prod_hi,
   output logic [3:0]       flags,
   output logic             ill,
   output logic             busy,
   output logic             done
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0]   dout_q, dout_d;
   logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;
   logic [3:0]         flags_q, flags_d;
   logic               ill_q, ill_d;
   logic               done_q, done_d;

   logic               mul_op;
   logic               mul_busy;
   logic               mul_last;
   logic [2*WIDTH-1:0] mul_prod;
   logic               single_go;

   logic [WIDTH-1:0]   opb;
   logic [WIDTH:0]     add_r;
   logic [WIDTH:0]     sub_r;
   logic [WIDTH-1:0]   res;
   logic               c, v, bad;
   logic [WIDTH-1:0]   wres, whi;
   logic               wc, wv, will, load;

`ifdef ALU_SEQ_MUL_EN
   logic mul_go;

   assign mul_op = (alus == OP_MUL);
   assign mul_go = start & ~mul_busy & mul_op;

   alu_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .go     (mul_go),
      .mcand  (x),
      .mplier (bus),
      .busy   (mul_busy),
      .last   (mul_last),
      .prod   (mul_prod)
   );
`else
   assign mul_op   = 1'b0;
   assign mul_busy = 1'b0;
   assign mul_last = 1'b0;
   assign mul_prod = '0;
`endif

   assign single_go = start & ~mul_busy & ~mul_op;

   // inc/dec reuse the add/sub paths with a constant operand of 1
   assign opb   = (alus == OP_INC || alus == OP_DEC) ? WIDTH'(1) : bus;
   assign add_r = {1'b0, x} + {1'b0, opb};
   assign sub_r = {1'b0, x} - {1'b0, opb};

   always_comb begin
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      bad = 1'b0;

      case (alus)
         OP_ZERO: res = '0;
         OP_ADD, OP_INC: begin
            res = add_r[MSB:0];
            c   = add_r[WIDTH];
            v   = (x[MSB] == opb[MSB]) && (res[MSB] != x[MSB]);
         end
         OP_SUB, OP_DEC: begin
            res = sub_r[MSB:0];
            c   = sub_r[WIDTH];
            v   = (x[MSB] != opb[MSB]) && (res[MSB] != x[MSB]);
         end
         OP_AND:  res = x & bus;
         OP_OR:   res = x | bus;
         OP_NOT:  res = ~x;
         OP_XOR:  res = x ^ bus;
         OP_SHL: begin
            res = {x[MSB-1:0], 1'b0};
            c   = x[MSB];
         end
         OP_PASS: res = bus;
         default: bad = 1'b1;
      endcase

      wres = res;
      whi  = '0;
      wc   = c;
      wv   = v;
      will = bad;
      load = single_go;

      if (mul_last) begin
         wres = mul_prod[MSB:0];
         whi  = mul_prod[2*WIDTH-1:WIDTH];
         wc   = |mul_prod[2*WIDTH-1:WIDTH];
         wv   = wc;
         will = 1'b0;
         load = 1'b1;
      end

      dout_d    = dout_q;
      prod_hi_d = prod_hi_q;
      flags_d   = flags_q;
      ill_d     = ill_q;
      done_d    = load;

      if (load) begin
         dout_d          = wres;
         prod_hi_d       = whi;
         ill_d           = will;
         flags_d[FLAG_Z] = (wres == '0);
         flags_d[FLAG_N] = wres[MSB];
         flags_d[FLAG_C] = wc;
         flags_d[FLAG_V] = wv;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q    <= '0;
         prod_hi_q <= '0;
         flags_q   <= '0;
         ill_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         dout_q    <= dout_d;
         prod_hi_q <= prod_hi_d;
         flags_q   <= flags_d;
         ill_q     <= ill_d;
         done_q    <= done_d;
      end
   end

   assign dout    = dout_q;
   assign prod_hi = prod_hi_q;
   assign flags   = flags_q;
   assign ill     = ill_q;
   assign busy    = mul_busy;
   assign done    = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random stimulus for alu_seq (WIDTH=8) checked
// every cycle against an arithmetic model of the ALU's rules.
module tb_alu_seq;

   localparam int W = 8;
   localparam int M = 1 << W;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         start;
   logic [3:0]   alus;
   logic [W-1:0] x;
   logic [W-1:0] bus;
   logic [W-1:0] dout;
   logic [W-1:0] prod_hi;
   logic [3:0]   flags;
   logic         ill;
   logic         busy;
   logic         done;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   int m_dout = 0, m_hi = 0, m_flags = 0, m_ill = 0, m_done = 0;
   int m_rem = 0, m_pa = 0, m_pb = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .alus    (alus),
      .x       (x),
      .bus     (bus),
      .dout    (dout),
      .prod_hi (prod_hi),
      .flags   (flags),
      .ill     (ill),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void cmp(string name, logic [31:0] got,
                               logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, exp,
                  $time);
      end
   endfunction

   function automatic int sgn(int a);
      return (a >= M / 2) ? a - M : a;
   endfunction

   function automatic int fl(int r, int v, int c);
      return ((r >= M / 2) ? 8 : 0) + (v != 0 ? 4 : 0)
           + (c != 0 ? 2 : 0) + (r == 0 ? 1 : 0);
   endfunction

   // Reference: what each opcode must produce, from plain integer math.
   function automatic void model_single(int op, int a, int b);
      int r, s, c, v, bd;
      r = 0; c = 0; v = 0; bd = 0; s = 0;
      case (op)
         0: r = 0;
         1, 3: begin
            if (op == 3) b = 1;
            r = a + b;
            c = (r >= M) ? 1 : 0;
            s = sgn(a) + sgn(b);
            v = (s >= M / 2 || s < -M / 2) ? 1 : 0;
         end
         2, 4: begin
            if (op == 4) b = 1;
            r = a - b;
            c = (a < b) ? 1 : 0;
            s = sgn(a) - sgn(b);
            v = (s >= M / 2 || s < -M / 2) ? 1 : 0;
         end
         5: r = a & b;
         6: r = a | b;
         7: r = (M - 1) - a;
         8: r = a ^ b;
         9: begin r = a * 2; c = (a >= M / 2) ? 1 : 0; end
         10: r = b;
         default: bd = 1;
      endcase
      r = r & (M - 1);
      m_dout = r; m_hi = 0; m_ill = bd; m_done = 1;
      m_flags = fl(r, v, c);
   endfunction

   function automatic void model_step(bit r_i, bit s_i, int op, int a,
                                      int b);
      int old_rem, p, lo, hi;
      old_rem = m_rem;
      if (r_i) begin
         m_dout = 0; m_hi = 0; m_flags = 0; m_ill = 0; m_done = 0;
         m_rem = 0;
         return;
      end
      m_done = 0;
      if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            p  = m_pa * m_pb;
            lo = p % M;
            hi = p / M;
            m_dout = lo; m_hi = hi; m_ill = 0; m_done = 1;
            m_flags = fl(lo, hi != 0 ? 1 : 0, hi != 0 ? 1 : 0);
         end
      end
      if (s_i && old_rem == 0) begin
         if (MUL_EN && op == 11) begin
            m_rem = W; m_pa = a; m_pb = b;
         end else begin
            model_single(op, a, b);
         end
      end
   endfunction

   initial forever begin
      @(posedge clk);
      model_step(rst, start, int'(alus), int'(x), int'(bus));
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         cmp("done", done, m_done);
         cmp("busy", busy, m_rem > 0 ? 1 : 0);
         cmp("dout", dout, m_dout);
         cmp("prod_hi", prod_hi, m_hi);
         cmp("flags", flags, m_flags);
         cmp("ill", ill, m_ill);
      end
   end

   // Called at a falling edge: start is high at the next rising edge
   // (cycle 0); returns at the falling edge inside cycle 1.
   task automatic go(input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b);
      start = 1'b1; alus = op; x = a; bus = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; alus = '0; x = '0; bus = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      cmp("rst_dout", dout, 0);
      cmp("rst_flags", flags, 0);
      cmp("rst_busy_done", {busy, done, ill}, 0);
      rst = 1'b0;
      @(negedge clk);

      go(4'h1, 8'hFF, 8'h01);
      cmp("add_dout", dout, 8'h00);
      cmp("add_flags", flags, 4'b0011);
      cmp("add_done_busy", {done, busy}, 2'b10);

      go(4'h2, 8'h80, 8'h01);
      cmp("sub_dout", dout, 8'h7F);
      cmp("sub_flags", flags, 4'b0100);
      go(4'h4, 8'h00, 8'h33);
      cmp("dec_dout", dout, 8'hFF);
      cmp("dec_flags", flags, 4'b1010);
      @(negedge clk);
      cmp("hold_done", done, 0);
      cmp("hold_dout", dout, 8'hFF);

      go(4'hF, 8'h12, 8'h34);
      cmp("undef_out", {dout, prod_hi}, 16'h0000);
      cmp("undef_ill", {ill, flags}, 5'b10001);
      go(4'h1, 8'h01, 8'h01);
      cmp("clr_ill", {ill, dout}, 9'h002);

      go(4'hB, 8'h03, 8'h05);
`ifdef ALU_SEQ_MUL_EN
      for (int c = 1; c <= 9; c++) begin
         if (c <= 8) begin
            cmp("mul_busy", {busy, done}, 2'b10);
         end else begin
            cmp("mul_fin", {busy, done}, 2'b01);
            cmp("mul_3x5", {dout, prod_hi}, 16'h0F00);
         end
         if (c < 9) @(negedge clk);
      end
      go(4'hB, 8'hFF, 8'hFF);
      for (int c = 1; c <= 9; c++) begin
         if (c <= 8) begin
            cmp("mul_busy", {busy, done}, 2'b10);
         end else begin
            cmp("mul_fin", {busy, done}, 2'b01);
            cmp("mul_ff", {dout, prod_hi}, 16'h01FE);
            cmp("mul_ff_flags", flags, 4'b0110);
         end
         if (c == 3) begin
            start = 1'b1; alus = 4'h1; x = 8'h01; bus = 8'h01;
         end else begin
            start = 1'b0;
         end
         if (c < 9) @(negedge clk);
      end
      go(4'hB, 8'h0F, 8'h11);
      repeat (8) @(negedge clk);
      cmp("mul_0f", {done, dout, prod_hi}, 17'h1FF00);
      cmp("mul_0f_flags", flags, 4'b1000);
      go(4'h1, 8'h01, 8'h02);
      cmp("b2b_add", {done, dout, prod_hi}, 17'h10300);

      go(4'hB, 8'h55, 8'h66);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cmp("abort_out", {dout, prod_hi, flags, ill, busy, done}, 0);
      go(4'h1, 8'h10, 8'h20);
      cmp("abort_add", {done, dout}, 9'h130);
`else
      cmp("nomul_ill", {ill, flags, busy}, 6'b100010);
      cmp("nomul_out", {dout, prod_hi}, 16'h0000);
      go(4'h9, 8'hC1, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cmp("rst_clear", {dout, flags, done}, 0);
`endif

      for (int i = 0; i < 1500; i++) begin
         rst   = ($urandom_range(0, 80) == 0);
         start = ($urandom_range(0, 2) != 0);
         alus  = ($urandom_range(0, 4) == 0) ? 4'hB
                                             : 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: x = 8'hFF;
            1: x = 8'h80;
            2: x = 8'h7F;
            default: x = 8'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: bus = 8'h01;
            1: bus = 8'hFF;
            2: bus = 8'h80;
            default: bus = 8'($urandom);
         endcase
         @(negedge clk);
      end
      rst = 1'b0; start = 1'b0;
      repeat (12) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: timeout reached, expected $finish");
      $fatal(1, "timeout");
   end

endmodule
